// File: rtl/barrel_shift_pkg.sv
// barrel_shift shared definitions.
// Default geometry and rotate direction encoding.
package barrel_shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/rotate_stage.sv
// One log-shifter stage of barrel_shift.
// Rotates by a fixed DIST when en is set, else passes d.
module rotate_stage
  import barrel_shift_pkg::*;
#(
  parameter int   WIDTH = WIDTH_DEF,
  parameter int   DIST  = 1,
  parameter dir_e DIR   = DIR_RIGHT
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r;

  if (DIR == DIR_LEFT) begin : g_left
    assign r = {d[WIDTH-DIST-1:0],
                d[WIDTH-1:WIDTH-DIST]};
  end else begin : g_right
    assign r = {d[DIST-1:0],
                d[WIDTH-1:DIST]};
  end

  // pass-through unless this bit of the amount is set
  always_comb begin
    q = d;
    if (en) q = r;
  end

endmodule

// File: rtl/barrel_shift.sv
// 32-bit registered barrel rotator.
// Two log chains (left/right), direction mux, one output register.
module barrel_shift
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             direction,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] l_res;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] nxt;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stg
    logic [WIDTH-1:0] li;
    logic [WIDTH-1:0] ri;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] ro;

    if (k == 0) begin : g_first
      assign li = a;
      assign ri = a;
    end else begin : g_next
      assign li = g_stg[k-1].lo;
      assign ri = g_stg[k-1].ro;
    end

    rotate_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .DIR   (DIR_LEFT)
    ) u_left (
      .d  (li),
      .en (amt[k]),
      .q  (lo)
    );

    rotate_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .DIR   (DIR_RIGHT)
    ) u_right (
      .d  (ri),
      .en (amt[k]),
      .q  (ro)
    );
  end

  assign l_res = g_stg[AMT_W-1].lo;
  assign r_res = g_stg[AMT_W-1].ro;

  // pick the chain matching the requested direction
  always_comb begin
    nxt = r_res;
    if (direction == DIR_LEFT) nxt = l_res;
  end

  // result register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y <= '0;
    else        y <= nxt;
  end

endmodule

// File: tb/tb_barrel_shift.sv
// Scoreboard bench for barrel_shift.
// Driver queues expected results; monitor pops one per edge.
module tb_barrel_shift;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        direction;
  logic [31:0] y;

  typedef struct {
    logic [31:0] y;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  barrel_shift dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .amt       (amt),
    .direction (direction),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit-permutation reference: each source bit moves n places around a ring
  function automatic logic [31:0] ref_rot(
    input logic [31:0] v,
    input int          n,
    input logic        left
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (left) r[(i + n) % 32] = v[i];
      else      r[i] = v[(i + n) % 32];
    end
    return r;
  endfunction

  task automatic check_now(
    input string       tag,
    input logic [31:0] want
  );
    checks++;
    if (y !== want) begin
      errors++;
      $display("FAIL %s: y=%h expected %h", tag, y, want);
    end
  endtask

  // drive at negedge, hold for n cycles, one expected result per edge
  task automatic issue(
    input logic [31:0] va,
    input int          vamt,
    input logic        vdir,
    input int          n,
    input logic [31:0] want,
    input string       tag
  );
    exp_t e;
    a         = va;
    amt       = 5'(vamt);
    direction = vdir;
    for (int c = 0; c < n; c++) begin
      e.y   = want;
      e.tag = tag;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  // monitor: result of the previous edge's inputs, sampled just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y !== e.y) begin
          errors++;
          $display("FAIL %s: y=%h expected %h", e.tag, y, e.y);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    int          ramt;
    logic        rdir;
    int          hold;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b1;
    a         = 32'h0000_0099;
    amt       = 5'd7;
    direction = 1'b1;

    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_immediate", 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_now("reset_hold", 32'h0);
    end

    rst_n = 1'b1;
    issue(32'h99, 7, 1'b1, 2, 32'h0000_4C80, "post_reset_l7");

    issue(32'h99, 0,  1'b1, 2, 32'h0000_0099, "l0");
    issue(32'h99, 0,  1'b0, 2, 32'h0000_0099, "r0");
    issue(32'h99, 1,  1'b1, 2, 32'h0000_0132, "l1");
    issue(32'h99, 1,  1'b0, 2, 32'h8000_004C, "r1");
    issue(32'h99, 4,  1'b1, 2, 32'h0000_0990, "l4");
    issue(32'h99, 4,  1'b0, 2, 32'h9000_0009, "r4");
    issue(32'h99, 7,  1'b0, 2, 32'h3200_0001, "r7");
    issue(32'h99, 31, 1'b1, 2, 32'h8000_004C, "l31");
    issue(32'h99, 31, 1'b0, 2, 32'h0000_0132, "r31");
    issue(32'h99, 7,  1'b1, 2, 32'h0000_4C80, "l7");

    // async reset mid-stream: in-flight r1 must never appear
    a         = 32'h99;
    amt       = 5'd1;
    direction = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_now("midstream_reset", 32'h0);
    @(negedge clk);
    check_now("midstream_hold", 32'h0);
    rst_n = 1'b1;
    issue(32'h99, 1, 1'b0, 1, 32'h8000_004C, "post_reset_r1");

    // latency: new vector every cycle
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      ramt = $urandom_range(0, 31);
      rdir = 1'($urandom_range(0, 1));
      issue(ra, ramt, rdir, 1, ref_rot(ra, ramt, rdir), "b2b");
    end

    // random sweep with mixed hold lengths
    for (int i = 0; i < 300; i++) begin
      ra   = $urandom;
      ramt = $urandom_range(0, 31);
      rdir = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 2);
      issue(ra, ramt, rdir, hold, ref_rot(ra, ramt, rdir), "rand");
    end

    // every direction/amount once
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 32; n++) begin
        ra = $urandom;
        issue(ra, n, 1'(d), 1, ref_rot(ra, n, 1'(d)), "sweep");
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
